// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over a shared 2*XLEN shift register.
// Shift-add multiplier and restoring divider operate on magnitudes; sign correction is applied on exit.
//
// state  | meaning
// S_IDLE | waiting for MD_start
// S_RUN  | XLEN iterations of shift-add or restoring divide
// S_DONE | MD_done pulse, MD_result valid; may accept a back-to-back start
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            SYS_clk,
  input  logic            SYS_reset,
  input  logic            MD_start,
  input  logic [2:0]      MD_funct3,
  input  logic [XLEN-1:0] MD_rs1_data,
  input  logic [XLEN-1:0] MD_rs2_data,
  output logic            MD_busy,
  output logic            MD_done,
  output logic [XLEN-1:0] MD_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   addend_q, addend_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic            accept, is_div, rs1_signed, rs2_signed, rs1_neg, rs2_neg;
  logic            div_zero, div_ovf, special, start_neg;
  logic [XLEN-1:0] rs1_mag, rs2_mag, special_res;
  logic [XLEN:0]   mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_step, div_step, step, prod_c;
  logic [XLEN-1:0] quo, rem, fin_res;

  always_comb begin
    accept     = MD_start && (state_q != S_RUN);
    is_div     = MD_funct3[2];
    rs1_signed = (MD_funct3 inside {3'b001, 3'b010, 3'b100, 3'b110});
    rs2_signed = (MD_funct3 inside {3'b001, 3'b100, 3'b110});
    rs1_neg    = rs1_signed && MD_rs1_data[XLEN-1];
    rs2_neg    = rs2_signed && MD_rs2_data[XLEN-1];
    rs1_mag    = rs1_neg ? (~MD_rs1_data + 1'b1) : MD_rs1_data;
    rs2_mag    = rs2_neg ? (~MD_rs2_data + 1'b1) : MD_rs2_data;
    div_zero   = (MD_rs2_data == '0);
    div_ovf    = !MD_funct3[0] && (MD_rs1_data == MIN_NEG) && (MD_rs2_data == '1);
    special    = is_div && (div_zero || div_ovf);
    if (div_zero) special_res = MD_funct3[1] ? MD_rs1_data : '1;
    else          special_res = MD_funct3[1] ? '0 : MIN_NEG;
    // Remainder takes the dividend's sign; everything else is the sign xor.
    start_neg  = (is_div && MD_funct3[1]) ? rs1_neg : (rs1_neg ^ rs2_neg);
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, addend_q} : '0);
    mul_step  = {mul_sum, acc_q[XLEN-1:1]};
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, addend_q};
    div_step  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    step      = funct3_q[2] ? div_step : mul_step;
    prod_c    = neg_q ? (~step + 1'b1) : step;
    quo       = step[XLEN-1:0];
    rem       = step[2*XLEN-1:XLEN];
    if (funct3_q[2]) begin
      if (funct3_q[1]) fin_res = neg_q ? (~rem + 1'b1) : rem;
      else             fin_res = neg_q ? (~quo + 1'b1) : quo;
    end else begin
      fin_res = (funct3_q[1:0] == 2'b00) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q  <= S_IDLE;
      funct3_q <= '0;
      addend_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addend_q <= addend_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = special ? S_DONE : S_RUN;
      S_RUN:   if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = accept ? (special ? S_DONE : S_RUN) : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    funct3_d = funct3_q;
    addend_d = addend_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (state_q == S_RUN) begin
      acc_d = step;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) result_d = fin_res;
    end else if (accept) begin
      funct3_d = MD_funct3;
      neg_d    = start_neg;
      addend_d = is_div ? rs2_mag : rs1_mag;
      acc_d    = {{XLEN{1'b0}}, (is_div ? rs1_mag : rs2_mag)};
      cnt_d    = CNT_LOAD;
      if (special) result_d = special_res;
    end
  end

  always_comb begin
    MD_busy   = (state_q == S_RUN);
    MD_done   = (state_q == S_DONE);
    MD_result = result_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected result and completion cycle,
// a negedge monitor pops and compares whenever MD_done is seen.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] res;

  muldiv_unit #(.XLEN(32)) dut (
    .SYS_clk(clk), .SYS_reset(rst), .MD_start(start), .MD_funct3(f3),
    .MD_rs1_data(a), .MD_rs2_data(b), .MD_busy(busy), .MD_done(done), .MD_result(res)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          id;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0, n_err = 0, op_id = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    longint      lx, ly, sp;
    int          ix, iy, t;
    logic [31:0] r;
    ix = x; iy = y; lx = ix; ly = iy;
    r = '0;
    case (f)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; r = p[31:0]; end
      3'd1: begin sp = lx * ly; p = sp; r = p[63:32]; end
      3'd2: begin sp = lx * longint'({32'b0, y}); p = sp; r = p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
      3'd4: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin t = ix / iy; r = t; end
      end
      3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) r = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h0;
        else begin t = ix % iy; r = t; end
      end
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    return f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_exp(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] expv);
    f3 = f; a = x; b = y; start = 1'b1;
    q.push_back('{expv, cyc + (is_special(f, x, y) ? 1 : 33), op_id});
    op_id++;
    tick();
    start = 1'b0;
    f3 = 3'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    issue_exp(f, x, y, model(f, x, y));
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60 && !done; k++) tick();
    check("wait_done_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 80 && q.size() != 0; k++) tick();
    if (q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
    tick();
  endtask

  always @(negedge clk) begin
    if (done) begin
      check("busy_done_exclusive", 32'(busy), 32'd0);
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check($sformatf("result_op%0d", e.id), res, e.res);
        check($sformatf("done_cycle_op%0d", e.id), 32'(cyc), 32'(e.cyc));
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [31:0] x, y;
    logic [2:0]  f;

    tick(); tick(); tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", res, 32'd0);
    rst = 1'b0;
    tick();

    // mul with busy window
    c = cyc;
    issue_exp(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    check("mul_busy_c1", 32'(busy), 32'd1);
    repeat (31) tick();
    check("mul_busy_c32", 32'(busy), 32'd1);
    tick();
    check("mul_busy_c33", 32'(busy), 32'd0);
    wait_drain();

    issue_exp(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000); wait_drain();
    issue_exp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); wait_drain();
    issue_exp(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_drain();
    issue_exp(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD); wait_drain();
    issue_exp(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF); wait_drain();
    issue_exp(3'd5, 32'd100, 32'd7, 32'd14); wait_drain();
    issue_exp(3'd7, 32'd100, 32'd7, 32'd2); wait_drain();

    // special cases: done in cycle 1, no busy
    issue_exp(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    check("sp_divu0_busy", 32'(busy), 32'd0); wait_drain();
    issue_exp(3'd6, 32'd5, 32'd0, 32'd5);
    check("sp_rem0_busy", 32'(busy), 32'd0); wait_drain();
    issue_exp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    check("sp_divovf_busy", 32'(busy), 32'd0); wait_drain();
    issue_exp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    check("sp_removf_busy", 32'(busy), 32'd0); wait_drain();

    // start during RUN ignored, then back-to-back from DONE
    c = cyc;
    issue(3'd4, 32'd1000, 32'hFFFF_FFFD);
    repeat (9) tick();
    f3 = 3'd5; a = 32'd1; b = 32'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    check("ignored_start_done_cycle", 32'(cyc), 32'(c + 33));
    issue(3'd5, 32'd100, 32'd7);
    wait_drain();

    // reset mid-RUN, with a start held alongside reset
    c = cyc;
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (14) tick();
    rst = 1'b1;
    q.delete();
    tick();
    check("rst_busy_c16", 32'(busy), 32'd0);
    check("rst_result_c16", res, 32'd0);
    check("rst_done_c16", 32'(done), 32'd0);
    f3 = 3'd5; a = 32'd9; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; rst = 1'b0;
    check("rst_start_dropped_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("rst_idle_busy", 32'(busy), 32'd0);
    check("rst_idle_result", res, 32'd0);
    issue(3'd0, 32'd6, 32'd7);
    wait_drain();

    // randomized, with random back-to-back issue from DONE
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom);
      x = pick();
      y = pick();
      if (!(done && $urandom_range(1) == 1)) begin
        wait_drain();
        repeat ($urandom_range(2)) tick();
      end
      issue(f, x, y);
      wait_done();
    end
    wait_drain();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle execution unit for the eight RV32M operations (mul, mulh, mulhsu, mulhu, div, divu, rem, remu). It sits directly downstream of the data path's R-type decode. The data path presents funct3 and both register operands with a one-cycle start pulse, stalls PC while the unit is busy, and writes the result to rd in the cycle done is asserted. One shared 2×XLEN shift register serves both the shift-add multiplier and the restoring divider.

## Interface
- XLEN, 32, operand/result width; iteration count equals XLEN
- SYS_clk  input  1  system clock, all state updates on rising edge
- SYS_reset  input  1  synchronous, active-high reset
- MD_start  input  1  request pulse; accepted only in IDLE or DONE state
- MD_funct3  input  3  operation select: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- MD_rs1_data  input  XLEN  multiplicand / dividend
- MD_rs2_data  input  XLEN  multiplier / divisor
- MD_busy  output  1  high while in RUN state
- MD_done  output  1  one-cycle pulse; MD_result valid in that cycle
- MD_result  output  XLEN  registered result, held until next accepted start

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- On accepted start, capture funct3, the operand magnitudes, and the result sign flag. Signedness per op:
  - mulh: both operands signed.
  - mulhsu: rs1 signed, rs2 unsigned.
  - div/rem: both operands signed.
  - Others: unsigned.
- Result sign:
  - mul-family: negate if exactly one signed operand is negative.
  - div: negate if the signs differ.
  - rem: sign follows the dividend.
- Special cases, detected at start and going IDLE/DONE → DONE directly:
  - Divide by zero: quotient = all ones; remainder = rs1 unmodified.
  - Signed overflow (rs1 = 0x8000_0000, rs2 = 0xFFFF_FFFF, div/rem only): quotient = 0x8000_0000; remainder = 0.
- Normal path: IDLE/DONE → RUN, exactly XLEN iterations, one bit per cycle.
  - Multiply: shift-add over the 2×XLEN product. mul returns bits [XLEN-1:0] of the signed-corrected product; mulh/mulhsu/mulhu return bits [2XLEN-1:XLEN].
  - Divide: restoring algorithm. Quotient rounds toward zero.
  - Sign correction (two's-complement negate of the 2×XLEN product, or of the quotient/remainder) is applied on the RUN → DONE edge.
- DONE → IDLE when MD_start is low; DONE → RUN/DONE when MD_start is high (back-to-back issue).
- MD_start in RUN is ignored; no queueing, no effect on the operation in flight.
- Operand inputs are sampled only on the accepting edge; later changes have no effect.

## Timing
- Reset values: state IDLE, MD_busy 0, MD_done 0, MD_result 0, all internal registers 0.
- Start high in cycle 0 (sampled at the end of cycle 0):
  - Normal ops: MD_busy = 1 in cycles 1..XLEN; MD_done = 1 and MD_result valid in cycle XLEN+1 (cycle 33 for XLEN = 32).
  - Special cases: MD_busy stays 0; MD_done = 1 in cycle 1.
- MD_done is never high for two consecutive cycles unless a new start was accepted in the DONE cycle and was a special case.
- MD_busy and MD_done are never both high.
- Reset asserted mid-RUN: the next cycle is IDLE, with no MD_done and MD_result = 0.
- Reset and MD_start high together: reset wins and the start is dropped.
- MD_result changes only on the RUN → DONE or special-case → DONE edge, or on reset.

## Test plan
- mul 7 × 0xFFFF_FFFD (−3) → MD_result 0xFFFF_FFEB, MD_done in cycle 33, MD_busy high cycles 1–32.
- mulh 0x8000_0000 × 0x8000_0000 → 0x4000_0000. mulhu 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE. mulhsu 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFF.
- div 0xFFFF_FFF9 (−7) / 2 → 0xFFFF_FFFD (−3); rem same operands → 0xFFFF_FFFF (−1); divu 100/7 → 14; remu 100/7 → 2.
- Special cases, each with MD_done in cycle 1 and MD_busy never high:
  - divu 5/0 → 0xFFFF_FFFF; rem 5/0 → 5.
  - div 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000; rem same operands → 0.
- Start a div, pulse MD_start with different operands in cycle 10 → ignored; the original result still appears in cycle 33. Then issue a new start in the DONE cycle → the second result appears 33 cycles later.
- Assert SYS_reset in cycle 15 of a mul → MD_busy 0 and MD_result 0 from the next cycle, no MD_done afterwards. A fresh start then completes normally.
